cpu_test_sequencer: RTL
=======================

# cpu_test_sequencer

Synthesizable, parametrised run controller for the FRANK6000 CPU. It streams a program into the CPU instruction memory through the CPU's write port, pulses the CPU reset, and enables execution. It then watches `WREG` for an expected result, or times out, and reports pass/fail. It replaces hand-written simulation benches and lets on-board self-test and regression share one mechanism.

## Interface
Parameters:
- `ADDR_W`, 8: instruction memory address width.
- `INSTR_W`, 16: instruction word width.
- `DATA_W`, 8: `WREG` width.
- `CYC_W`, 16: run cycle counter width.
- `RST_CYCLES`, 1: CPU reset pulse length in cycles (≥1).
- `STABLE`, 4: consecutive matching cycles required for pass (≥1).

Ports:
- `i_clk` in 1: clock; the only clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_start` in 1: begin a sequence; sampled in IDLE or DONE only.
- `i_abort` in 1: return to IDLE from any state.
- `i_len` in ADDR_W+1: number of program words, 0..2^ADDR_W; sampled with `i_start`.
- `i_max_cycles` in CYC_W: run timeout; sampled with `i_start`; 0 means immediate timeout.
- `i_expected` in DATA_W: pass value for `WREG`; sampled with `i_start`.
- `i_valid` in 1: program word valid.
- `i_word` in INSTR_W: program word.
- `o_ready` out 1: accept program word.
- `o_instr_addr` out ADDR_W: to CPU `i_instr_addr`.
- `o_instr` out INSTR_W: to CPU `i_instr`.
- `o_we` out 1: to CPU `i_we`.
- `o_cpu_rst` out 1: to CPU `i_rst`.
- `o_on` out 1: to CPU `i_ON`.
- `i_wreg` in DATA_W: from CPU `o_WREG`.
- `o_done` out 1: sequence finished.
- `o_pass` out 1: result matched.
- `o_timeout` out 1: run hit `i_max_cycles` without a match.
- `o_cycles` out CYC_W: run cycles elapsed.

## Operation
- States: IDLE, LOAD, CRST, RUN, DONE.
- IDLE:
  - `i_start` latches `i_len`, `i_max_cycles` and `i_expected`.
  - Go to LOAD; if `i_len`==0, go to CRST directly.
- LOAD:
  - `o_ready`=1.
  - Each cycle with `i_valid & o_ready` is one transfer. The transfer registers `o_instr`←`i_word`, `o_instr_addr`←word index, and `o_we`←1 for exactly the next cycle.
  - Word index starts at 0 and increments per transfer.
  - `o_ready` drops in the cycle after the `i_len`-th transfer; the state moves to CRST in that same cycle, in which the final write is presented.
  - `i_valid` low inserts idle cycles with `o_we`=0; no write is lost.
- CRST: `o_cpu_rst`=1 and `o_on`=0 for `RST_CYCLES` cycles, then go to RUN.
- RUN:
  - `o_on`=1.
  - `o_cycles` increments each cycle, starting from 0 on the first RUN cycle.
  - A match counter increments while `i_wreg`==`i_expected` and clears on any mismatch.
  - When the match counter reaches `STABLE`: `o_pass`=1 and go to DONE.
  - Otherwise, when `o_cycles`==`i_max_cycles`: `o_timeout`=1 and go to DONE.
  - Pass and timeout in the same cycle: pass wins, `o_timeout`=0.
- DONE:
  - `o_on`=0 (CPU frozen); `o_done`=1.
  - `o_pass`, `o_timeout` and `o_cycles` hold.
  - `i_start` clears all three flags and restarts from IDLE behaviour in the same cycle.
- `i_abort` in any state: next cycle IDLE, all outputs at reset values. `i_abort` has priority over `i_start`.
- `i_start` in LOAD, CRST or RUN is ignored.

## Timing
- Reset values: all outputs 0; state IDLE.
- All outputs are registered; no combinational input-to-output path.
- Load: one word per cycle at full throughput. Write latency is 1 cycle from transfer to `o_we`.
- Sequence latency with continuous `i_valid`: `i_len` load cycles + 1 final-write cycle + `RST_CYCLES` + run cycles.
- `o_cycles` saturates at `i_max_cycles`; it never wraps.
- Word index reaching 2^ADDR_W ends the load; the address wraps only by exiting the state.
- `i_rst` mid-sequence: immediate return to reset values; the CPU is left disabled (`o_on`=0).

## Structure
- Package `cpu_test_pkg`:
  - state enum for IDLE/LOAD/CRST/RUN/DONE;
  - default width constants `ADDR_W`, `INSTR_W`, `DATA_W`, `CYC_W`.
- Sub-module `cpu_test_monitor`: the run cycle counter plus the match counter. It outputs pass and timeout strobes with pass-over-timeout priority.
- Top level holds the FSM and the load datapath.

## Test plan
- `i_len`=3 with continuous `i_valid`, words 0x1111/0x2222/0x3333 → `o_we` high for 3 cycles at addresses 0,1,2 with those words; then `o_cpu_rst` for 1 cycle; then `o_on`=1.
- Same load with `i_valid` toggling every cycle → 3 writes, correct addresses, `o_we` gaps aligned with `i_valid` gaps.
- Program from `02_add.hex`, correct `i_expected`, `STABLE`=4, `i_max_cycles`=1000 → `o_done`=1, `o_pass`=1, `o_timeout`=0, `o_cycles` < 1000.
- Same program, wrong `i_expected`, `i_max_cycles`=50 → `o_timeout`=1, `o_pass`=0, `o_cycles`=50, `o_on`=0 in DONE.
- Forced `i_wreg` whose match counter reaches `STABLE` exactly on cycle `i_max_cycles` → `o_pass`=1, `o_timeout`=0.
- `i_abort` during RUN, and separately `i_rst` during LOAD → next cycle all outputs 0, state IDLE; a subsequent `i_start` runs a clean sequence.

Source files
------------

// File: rtl/cpu_test_pkg.sv
// Shared types and default widths for the FRANK6000 test sequencer.
package cpu_test_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int DATA_W  = 8;
    localparam int CYC_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CRST,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/cpu_test_monitor.sv
// Run-phase watcher: counts elapsed run cycles and consecutive WREG matches,
// and raises pass or timeout strobes (pass wins when both hit together).
module cpu_test_monitor #(
    parameter int DATA_W = 8,
    parameter int CYC_W  = 16,
    parameter int STABLE = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_run,
    input  logic [DATA_W-1:0] i_wreg,
    input  logic [DATA_W-1:0] i_expected,
    input  logic [CYC_W-1:0]  i_max_cycles,
    output logic [CYC_W-1:0]  o_cycles,
    output logic              o_pass_stb,
    output logic              o_timeout_stb
);

    localparam int M_W = $clog2(STABLE + 1);

    logic [M_W-1:0]   match_q, match_d, match_next;
    logic [CYC_W-1:0] cycles_q, cycles_d;

    always_comb begin
        match_next    = (i_wreg == i_expected) ? match_q + M_W'(1) : '0;
        o_pass_stb    = i_run && (match_next == M_W'(STABLE));
        o_timeout_stb = i_run && !o_pass_stb && (cycles_q == i_max_cycles);
        match_d       = match_q;
        cycles_d      = cycles_q;
        if (i_clear) begin
            match_d  = '0;
            cycles_d = '0;
        end else if (i_run) begin
            match_d = match_next;
            // The counter stops on the terminating cycle, so it saturates at the limit.
            if (!o_pass_stb && !o_timeout_stb) begin
                cycles_d = cycles_q + CYC_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            match_q  <= '0;
            cycles_q <= '0;
        end else begin
            match_q  <= match_d;
            cycles_q <= cycles_d;
        end
    end

    assign o_cycles = cycles_q;

endmodule

// File: rtl/cpu_test_sequencer.sv
// Run controller: streams a program into the CPU, pulses its reset, runs it
// and reports whether WREG settled on the expected value before the timeout.
module cpu_test_sequencer
    import cpu_test_pkg::*;
#(
    parameter int ADDR_W     = cpu_test_pkg::ADDR_W,
    parameter int INSTR_W    = cpu_test_pkg::INSTR_W,
    parameter int DATA_W     = cpu_test_pkg::DATA_W,
    parameter int CYC_W      = cpu_test_pkg::CYC_W,
    parameter int RST_CYCLES = 1,
    parameter int STABLE     = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [ADDR_W:0]    i_len,
    input  logic [CYC_W-1:0]   i_max_cycles,
    input  logic [DATA_W-1:0]  i_expected,
    input  logic               i_valid,
    input  logic [INSTR_W-1:0] i_word,
    output logic               o_ready,
    output logic [ADDR_W-1:0]  o_instr_addr,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_we,
    output logic               o_cpu_rst,
    output logic               o_on,
    input  logic [DATA_W-1:0]  i_wreg,
    output logic               o_done,
    output logic               o_pass,
    output logic               o_timeout,
    output logic [CYC_W-1:0]   o_cycles
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [ADDR_W:0]    len_q, len_d, cnt_q, cnt_d, cnt_inc;
    logic [CYC_W-1:0]   max_q, max_d;
    logic [DATA_W-1:0]  exp_q, exp_d;
    logic [RC_W-1:0]    rcnt_q, rcnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic ready_q, ready_d, we_q, we_d, cpu_rst_q, cpu_rst_d, on_q, on_d;
    logic done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
    logic start_ok, mon_clear, run_active, pass_stb, timeout_stb;

    assign start_ok   = i_start && !i_abort && (state_q == ST_IDLE || state_q == ST_DONE);
    assign mon_clear  = i_abort || start_ok;
    assign run_active = (state_q == ST_RUN);
    assign cnt_inc    = cnt_q + (ADDR_W + 1)'(1);

    cpu_test_monitor #(
        .DATA_W (DATA_W),
        .CYC_W  (CYC_W),
        .STABLE (STABLE)
    ) u_monitor (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clear       (mon_clear),
        .i_run         (run_active),
        .i_wreg        (i_wreg),
        .i_expected    (exp_q),
        .i_max_cycles  (max_q),
        .o_cycles      (o_cycles),
        .o_pass_stb    (pass_stb),
        .o_timeout_stb (timeout_stb)
    );

    always_comb begin
        // NOTE: every _d is defaulted first so no branch can leave one unassigned and infer a latch.
        state_d   = state_q;
        len_d     = len_q;
        max_d     = max_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        ready_d   = 1'b0;
        we_d      = 1'b0;
        cpu_rst_d = 1'b0;
        on_d      = 1'b0;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    len_d     = i_len;
                    max_d     = i_max_cycles;
                    exp_d     = i_expected;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    if (i_len == '0) begin
                        state_d   = ST_CRST;
                        cpu_rst_d = 1'b1;
                        rcnt_d    = '0;
                    end else begin
                        state_d = ST_LOAD;
                        ready_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                ready_d = 1'b1;
                if (i_valid && ready_q) begin
                    we_d    = 1'b1;
                    instr_d = i_word;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    cnt_d   = cnt_inc;
                    if (cnt_inc == len_q) begin
                        ready_d = 1'b0;
                        state_d = ST_CRST;
                    end
                end
            end
            ST_CRST: begin
                // Entered from LOAD with cpu_rst low: that cycle carries the last write.
                if (!cpu_rst_q) begin
                    cpu_rst_d = 1'b1;
                    rcnt_d    = '0;
                end else if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    on_d    = 1'b1;
                end else begin
                    cpu_rst_d = 1'b1;
                    rcnt_d    = rcnt_q + RC_W'(1);
                end
            end
            ST_RUN: begin
                on_d = 1'b1;
                if (pass_stb || timeout_stb) begin
                    state_d   = ST_DONE;
                    on_d      = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = pass_stb;
                    timeout_d = timeout_stb;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_abort) begin
            state_d   = ST_IDLE;
            len_d     = '0;
            max_d     = '0;
            exp_d     = '0;
            cnt_d     = '0;
            rcnt_d    = '0;
            addr_d    = '0;
            instr_d   = '0;
            ready_d   = 1'b0;
            we_d      = 1'b0;
            cpu_rst_d = 1'b0;
            on_d      = 1'b0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            max_q     <= '0;
            exp_q     <= '0;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            addr_q    <= '0;
            instr_q   <= '0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            cpu_rst_q <= 1'b0;
            on_q      <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            max_q     <= max_d;
            exp_q     <= exp_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            cpu_rst_q <= cpu_rst_d;
            on_q      <= on_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_instr_addr = addr_q;
    assign o_instr      = instr_q;
    assign o_we         = we_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_on         = on_q;
    assign o_done       = done_q;
    assign o_pass       = pass_q;
    assign o_timeout    = timeout_q;

endmodule
